// File: rtl/ddr3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_pkg
// Description : Shared types, command encodings, timing and mode-register
//               helpers for the DDR3 initialisation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr3_pkg;

    typedef enum logic [3:0] {
        ST_RST_HOLD = 4'd0,
        ST_CKE_WAIT = 4'd1,
        ST_XPR      = 4'd2,
        ST_MR2      = 4'd3,
        ST_MR3      = 4'd4,
        ST_MR1      = 4'd5,
        ST_MR0      = 4'd6,
        ST_ZQCL     = 4'd7,
        ST_DONE     = 4'd8
    } init_state_t;

    // {ras_n, cas_n, we_n}; DESEL additionally keeps every cs_n high
    localparam logic [2:0] c_cmd_nop   = 3'b111;
    localparam logic [2:0] c_cmd_mrs   = 3'b000;
    localparam logic [2:0] c_cmd_zqcl  = 3'b110;
    localparam logic [2:0] c_cmd_desel = 3'b111;

    localparam int c_t_mrd    = 4;
    localparam int c_t_zqinit = 512;

    localparam int c_mr0_cl_lsb  = 4;
    localparam int c_mr0_cl_a2   = 2;
    localparam int c_mr0_dll_rst = 8;
    localparam int c_mr0_wr_lsb  = 9;
    localparam int c_mr2_cwl_lsb = 3;

    localparam logic [15:0] c_mr1_val   = 16'h0006;
    localparam logic [15:0] c_mr3_val   = 16'h0000;
    localparam logic [15:0] c_zqcl_addr = 16'h0400;

    // ceil(t / period); the epsilon keeps exact multiples from rounding up
    function automatic int ns2cyc(input real t_ns, input real period_ns);
        int n;
        n = $rtoi(t_ns / period_ns);
        if ((real'(n) * period_ns) < (t_ns - 1.0e-9))
            n = n + 1;
        return n;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [15:0] mr0_val(input int cl, input int wr);
        logic [15:0] v;
        v = '0;
        if (cl >= 12) begin
            v[c_mr0_cl_lsb +: 3] = 3'(cl - 12);
            v[c_mr0_cl_a2]       = 1'b1;
        end else begin
            v[c_mr0_cl_lsb +: 3] = 3'(cl - 4);
        end
        // WR 5..8 encode linearly, 10/12/14 as WR/2, 16 wraps to 0
        if (wr <= 8)
            v[c_mr0_wr_lsb +: 3] = 3'(wr - 4);
        else if (wr < 16)
            v[c_mr0_wr_lsb +: 3] = 3'(wr / 2);
        v[c_mr0_dll_rst] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] mr2_val(input int cwl);
        logic [15:0] v;
        v = '0;
        v[c_mr2_cwl_lsb +: 3] = 3'(cwl - 5);
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_init_timer.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_init_timer
// Description : Loadable down-counter that stops at zero and flags done.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_init_timer #(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= WIDTH'(RESET_VAL);
        else if (i_load)
            r_count <= i_load_val;
        else if (r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ddr3_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_init_seq
// Description : DDR3 power-up / initialisation sequencer for 1..4 ranks.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_init_seq
    import ddr3_pkg::*;
#(
    parameter real DDR_CLK_PERIOD = 3.0,
    parameter int  RANKS          = 1,
    parameter int  ROW_W          = 14,
    parameter int  BANK_W         = 3,
    parameter int  CL             = 9,
    parameter int  CWL            = 7,
    parameter int  WR             = 10,
    parameter int  SIM_FAST       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reinit,
    output logic              ddr_reset_n,
    output logic              cke,
    output logic [RANKS-1:0]  cs_n,
    output logic              ras_n,
    output logic              cas_n,
    output logic              we_n,
    output logic [BANK_W-1:0] ba,
    output logic [ROW_W-1:0]  addr,
    output logic [RANKS-1:0]  odt,
    output logic              init_done
);

    localparam int c_t_rst = (SIM_FAST != 0) ? ns2cyc(200.0, DDR_CLK_PERIOD)
                                             : ns2cyc(200000.0, DDR_CLK_PERIOD);
    localparam int c_t_cke = (SIM_FAST != 0) ? ns2cyc(500.0, DDR_CLK_PERIOD)
                                             : ns2cyc(500000.0, DDR_CLK_PERIOD);
    localparam int c_t_xpr = imax(5, ns2cyc(170.0, DDR_CLK_PERIOD));
    localparam int c_t_mod = imax(12, ns2cyc(15.0, DDR_CLK_PERIOD));

    // Sized for the longest wait; in fast mode ZQINIT outgrows T_CKE
    localparam int c_t_max  = imax(imax(c_t_rst, c_t_cke), c_t_zqinit);
    localparam int c_cnt_w  = $clog2(c_t_max + 1);
    localparam int c_rank_w = (RANKS > 1) ? $clog2(RANKS) : 1;

    localparam logic [c_cnt_w-1:0]  c_ld_rst    = c_cnt_w'(c_t_rst - 1);
    localparam logic [c_cnt_w-1:0]  c_ld_cke    = c_cnt_w'(c_t_cke - 1);
    localparam logic [c_cnt_w-1:0]  c_ld_xpr    = c_cnt_w'(c_t_xpr - 1);
    localparam logic [c_cnt_w-1:0]  c_ld_mrd    = c_cnt_w'(c_t_mrd - 1);
    localparam logic [c_cnt_w-1:0]  c_ld_mod    = c_cnt_w'(c_t_mod - 1);
    localparam logic [c_cnt_w-1:0]  c_ld_zqinit = c_cnt_w'(c_t_zqinit - 1);
    localparam logic [c_rank_w-1:0] c_last_rank = c_rank_w'(RANKS - 1);
    localparam logic [15:0]         c_mr0       = mr0_val(CL, WR);
    localparam logic [15:0]         c_mr2       = mr2_val(CWL);

    init_state_t         r_state;
    init_state_t         w_next;
    logic [c_rank_w-1:0] r_rank;
    logic [c_rank_w-1:0] w_rank_next;
    logic                w_load;
    logic [c_cnt_w-1:0]  w_load_val;
    logic                w_tmr_done;
    logic                w_entering;
    logic [RANKS-1:0]    w_cs_rank;

    logic                w_reset_n;
    logic                w_cke;
    logic [RANKS-1:0]    w_cs_n;
    logic [2:0]          w_cmd;
    logic [BANK_W-1:0]   w_ba;
    logic [ROW_W-1:0]    w_addr;
    logic                w_done;

    // Reset pre-loads the RST_HOLD wait, as if the state had just been entered
    ddr3_init_timer #(
        .WIDTH     (c_cnt_w),
        .RESET_VAL (c_t_rst - 1)
    ) u_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RST_HOLD;
            r_rank  <= '0;
        end else begin
            r_state <= w_next;
            r_rank  <= w_rank_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_rank_next = r_rank;
        w_load      = 1'b0;
        w_load_val  = '0;
        case (r_state)
            ST_RST_HOLD: if (w_tmr_done) begin
                w_next = ST_CKE_WAIT; w_load = 1'b1; w_load_val = c_ld_cke;
            end
            ST_CKE_WAIT: if (w_tmr_done) begin
                w_next = ST_XPR; w_load = 1'b1; w_load_val = c_ld_xpr;
            end
            ST_XPR: if (w_tmr_done) begin
                w_next = ST_MR2; w_load = 1'b1; w_load_val = c_ld_mrd;
            end
            ST_MR2: if (w_tmr_done) begin
                w_next = ST_MR3; w_load = 1'b1; w_load_val = c_ld_mrd;
            end
            ST_MR3: if (w_tmr_done) begin
                w_next = ST_MR1; w_load = 1'b1; w_load_val = c_ld_mrd;
            end
            ST_MR1: if (w_tmr_done) begin
                w_next = ST_MR0; w_load = 1'b1; w_load_val = c_ld_mod;
            end
            ST_MR0: if (w_tmr_done) begin
                w_next = ST_ZQCL; w_load = 1'b1; w_load_val = c_ld_zqinit;
            end
            ST_ZQCL: if (w_tmr_done) begin
                w_load     = 1'b1;
                w_load_val = c_ld_mrd;
                if (r_rank == c_last_rank) begin
                    w_next = ST_DONE;
                end else begin
                    w_next      = ST_MR2;
                    w_rank_next = r_rank + 1'b1;
                end
            end
            ST_DONE: if (reinit) begin
                w_next      = ST_RST_HOLD;
                w_rank_next = '0;
                w_load      = 1'b1;
                w_load_val  = c_ld_rst;
            end
            default: begin
                w_next      = ST_RST_HOLD;
                w_rank_next = '0;
                w_load      = 1'b1;
                w_load_val  = c_ld_rst;
            end
        endcase
    end

    // Pins are decoded from the next state so each phase lands on its entry edge
    assign w_entering = (w_next != r_state);
    assign w_cs_rank  = ~(RANKS'(1) << w_rank_next);

    always_comb begin
        w_reset_n = 1'b1;
        w_cke     = 1'b1;
        w_cs_n    = '0;
        w_cmd     = c_cmd_nop;
        w_ba      = '0;
        w_addr    = '0;
        w_done    = 1'b0;
        case (w_next)
            ST_RST_HOLD: begin
                w_reset_n = 1'b0;
                w_cke     = 1'b0;
                w_cs_n    = '1;
                w_cmd     = c_cmd_desel;
            end
            ST_CKE_WAIT: begin
                w_cke  = 1'b0;
                w_cs_n = '1;
                w_cmd  = c_cmd_desel;
            end
            ST_MR2, ST_MR3, ST_MR1, ST_MR0, ST_ZQCL: begin
                w_cs_n = w_cs_rank;
                if (w_entering) begin
                    w_cmd = c_cmd_mrs;
                    case (w_next)
                        ST_MR2: begin w_ba = BANK_W'(2); w_addr = ROW_W'(c_mr2);     end
                        ST_MR3: begin w_ba = BANK_W'(3); w_addr = ROW_W'(c_mr3_val); end
                        ST_MR1: begin w_ba = BANK_W'(1); w_addr = ROW_W'(c_mr1_val); end
                        ST_MR0: begin w_ba = BANK_W'(0); w_addr = ROW_W'(c_mr0);     end
                        default: begin
                            w_cmd  = c_cmd_zqcl;
                            w_addr = ROW_W'(c_zqcl_addr);
                        end
                    endcase
                end
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ddr_reset_n           <= 1'b0;
            cke                   <= 1'b0;
            cs_n                  <= '1;
            {ras_n, cas_n, we_n}  <= 3'b111;
            ba                    <= '0;
            addr                  <= '0;
            init_done             <= 1'b0;
        end else begin
            ddr_reset_n           <= w_reset_n;
            cke                   <= w_cke;
            cs_n                  <= w_cs_n;
            {ras_n, cas_n, we_n}  <= w_cmd;
            ba                    <= w_ba;
            addr                  <= w_addr;
            init_done             <= w_done;
        end
    end

    assign odt = '0;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_init_seq
// Description : Cycle-accurate check of three sequencer configurations
//               against a phase-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_init_seq;

    typedef struct {
        int t_rst;
        int t_cke;
        int t_xpr;
        int t_mod;
        int ranks;
        int mr0;
        int mr2;
    } cfg_t;

    localparam int c_tmrd = 4;
    localparam int c_tzq  = 512;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic reinit = 1'b0;

    always #5 clk = ~clk;

    // a: defaults, b: two ranks, c: 2.5 ns with CL11/CWL8/WR12
    logic        a_rn, a_cke, a_ras, a_cas, a_we, a_done;
    logic [0:0]  a_cs, a_odt;
    logic [2:0]  a_ba;
    logic [13:0] a_addr;
    logic        b_rn, b_cke, b_ras, b_cas, b_we, b_done;
    logic [1:0]  b_cs, b_odt;
    logic [2:0]  b_ba;
    logic [13:0] b_addr;
    logic        c_rn, c_cke, c_ras, c_cas, c_we, c_done;
    logic [0:0]  c_cs, c_odt;
    logic [2:0]  c_ba;
    logic [13:0] c_addr;

    ddr3_init_seq #(.SIM_FAST(1)) u_dut_a (
        .clk(clk), .reset(reset), .reinit(reinit), .ddr_reset_n(a_rn), .cke(a_cke),
        .cs_n(a_cs), .ras_n(a_ras), .cas_n(a_cas), .we_n(a_we), .ba(a_ba),
        .addr(a_addr), .odt(a_odt), .init_done(a_done)
    );

    ddr3_init_seq #(.SIM_FAST(1), .RANKS(2)) u_dut_b (
        .clk(clk), .reset(reset), .reinit(reinit), .ddr_reset_n(b_rn), .cke(b_cke),
        .cs_n(b_cs), .ras_n(b_ras), .cas_n(b_cas), .we_n(b_we), .ba(b_ba),
        .addr(b_addr), .odt(b_odt), .init_done(b_done)
    );

    ddr3_init_seq #(.SIM_FAST(1), .DDR_CLK_PERIOD(2.5), .CL(11), .CWL(8), .WR(12)) u_dut_c (
        .clk(clk), .reset(reset), .reinit(reinit), .ddr_reset_n(c_rn), .cke(c_cke),
        .cs_n(c_cs), .ras_n(c_ras), .cas_n(c_cas), .we_n(c_we), .ba(c_ba),
        .addr(c_addr), .odt(c_odt), .init_done(c_done)
    );

    cfg_t cfg [3];
    int   s   [3];
    int   cyc;
    int   n_vec;
    int   n_miss;

    function automatic int ns2cyc(input real t, input real p);
        return int'($ceil(t / p));
    endfunction

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic cfg_t mk_cfg(input real p, input int ranks, input int mr0, input int mr2);
        cfg_t c;
        c.t_rst = ns2cyc(200.0, p);
        c.t_cke = ns2cyc(500.0, p);
        c.t_xpr = max2(5, ns2cyc(170.0, p));
        c.t_mod = max2(12, ns2cyc(15.0, p));
        c.ranks = ranks;
        c.mr0   = mr0;
        c.mr2   = mr2;
        return c;
    endfunction

    function automatic int done_rel(input cfg_t c);
        return c.t_rst + c.t_cke + c.t_xpr + c.ranks * (3 * c_tmrd + c.t_mod + c_tzq);
    endfunction

    // Expected pins rel edges after the sequence (re)started
    function automatic logic [63:0] exp_vec(input cfg_t c, input int rel);
        logic        rn, ck, dn;
        logic [3:0]  cs;
        logic [2:0]  cmd, bank;
        logic [13:0] a;
        int          base, per, r, o, all1;
        rn = 1'b1; ck = 1'b1; dn = 1'b0; cmd = 3'b111; bank = 3'd0; a = 14'd0;
        all1 = (1 << c.ranks) - 1;
        cs   = 4'(all1);
        base = c.t_rst + c.t_cke + c.t_xpr;
        per  = 3 * c_tmrd + c.t_mod + c_tzq;
        if (rel < c.t_rst) begin
            rn = 1'b0; ck = 1'b0;
        end else if (rel < c.t_rst + c.t_cke) begin
            ck = 1'b0;
        end else if (rel < base) begin
            cs = 4'd0;
        end else if (rel < base + c.ranks * per) begin
            r  = (rel - base) / per;
            o  = (rel - base) % per;
            cs = 4'(all1 & ~(1 << r));
            if (o == 0) begin
                cmd = 3'b000; bank = 3'd2; a = 14'(c.mr2);
            end else if (o == c_tmrd) begin
                cmd = 3'b000; bank = 3'd3;
            end else if (o == 2 * c_tmrd) begin
                cmd = 3'b000; bank = 3'd1; a = 14'h0006;
            end else if (o == 3 * c_tmrd) begin
                cmd = 3'b000; bank = 3'd0; a = 14'(c.mr0);
            end else if (o == 3 * c_tmrd + c.t_mod) begin
                cmd = 3'b110; a = 14'h0400;
            end
        end else begin
            cs = 4'd0; dn = 1'b1;
        end
        return 64'({rn, ck, cs, cmd, bank, a, 4'b0000, dn});
    endfunction

    function automatic logic [63:0] obs_vec(input int i);
        case (i)
            0:       return 64'({a_rn, a_cke, 4'(a_cs), a_ras, a_cas, a_we, a_ba, a_addr, 4'(a_odt), a_done});
            1:       return 64'({b_rn, b_cke, 4'(b_cs), b_ras, b_cas, b_we, b_ba, b_addr, 4'(b_odt), b_done});
            default: return 64'({c_rn, c_cke, 4'(c_cs), c_ras, c_cas, c_we, c_ba, c_addr, 4'(c_odt), c_done});
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (reset)
                s[i] = cyc;
            else if (reinit && (cyc - 1 - s[i]) >= done_rel(cfg[i]))
                s[i] = cyc;
        end
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("dut%0d rel=%0d", i, cyc - s[i]), obs_vec(i), exp_vec(cfg[i], cyc - s[i]));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst_async dut%0d", i), obs_vec(i), exp_vec(cfg[i], 0));
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int target;
        int budget;
        cyc = 0; n_vec = 0; n_miss = 0;
        cfg[0] = mk_cfg(3.0, 1, 'h0B50, 'h0010);
        cfg[1] = mk_cfg(3.0, 2, 'h0B50, 'h0010);
        cfg[2] = mk_cfg(2.5, 1, 'h0D70, 'h0018);
        for (int i = 0; i < 3; i++) s[i] = 0;

        #2;
        pulse_reset();
        step();

        // reset landing somewhere inside the first rank's MRS/ZQCL issue window
        target = 291 + int'($urandom_range(0, 23));
        while ((cyc - s[0]) < target) step();
        pulse_reset();

        // reinit while every configuration is still before DONE
        target = 234 + int'($urandom_range(0, 50));
        while ((cyc - s[0]) < target) step();
        reinit = 1'b1;
        step();
        reinit = 1'b0;

        budget = 0;
        while (!b_done && budget < 3000) begin
            step();
            budget++;
        end
        chk("done_timeout", 64'(b_done), 64'd1);

        repeat ($urandom_range(0, 20)) step();
        reinit = 1'b1;
        step();
        reinit = 1'b0;

        for (int k = 0; k < 4000; k++) begin
            if (k == 2000 + int'($urandom_range(0, 400)))
                pulse_reset();
            step();
            reinit = ($urandom_range(0, 249) == 0);
        end
        reinit = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
